rx_control: RTL and testbench

Receive-side system controller. Parses command frames arriving byte-by-byte from the UART receiver and turns them into register-file write/read strobes and ALU operation requests. Sits between the UART RX block and the register file and ALU, mirroring the transmit-side controller that returns read data and ALU results. Owns the ALU clock-gate enable.

---
 rtl/rx_control_pkg.sv | 26 ++
 rtl/rx_timeout_counter.sv | 31 +++
 rtl/rx_control.sv | 158 +++++++++++++++
 tb/tb_rx_control.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rx_control_pkg.sv
// Shared command codes, FSM state encoding and operand addresses for the
// receive-side controller (rx_control) and its helpers.
package rx_control_pkg;

   localparam logic [7:0] CMD_WR  = 8'hAA;
   localparam logic [7:0] CMD_RD  = 8'hBB;
   localparam logic [7:0] CMD_OPS = 8'hCC;
   localparam logic [7:0] CMD_ALU = 8'hDD;

   localparam int OP_A_ADDR = 0;
   localparam int OP_B_ADDR = 1;

   localparam int ALU_FUN_W = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WR_ADDR   = 3'd1,
      WR_DATA   = 3'd2,
      RD_ADDR   = 3'd3,
      OP_A      = 3'd4,
      OP_B      = 3'd5,
      ALU_FUN_S = 3'd6,
      ALU_WAIT  = 3'd7
   } state_e;

endpackage

// File: rtl/rx_timeout_counter.sv
// Mid-frame inactivity timer: a down-counter reloaded on clear or when idle,
// raising expire_o on the last counted cycle of an uninterrupted busy stretch.
module rx_timeout_counter #(
   parameter int CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= CW'(CYCLES);
      end else if (clr_i || !en_i) begin
         cnt_q <= CW'(CYCLES);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // Terminal count of 1: the controller acts on the edge that completes
   // CYCLES idle cycles after the last accepted byte.
   assign expire_o = en_i && !clr_i && (cnt_q == CW'(1));

endmodule

// File: rtl/rx_control.sv
// Receive-side command parser: turns UART byte frames into register-file
// write/read strobes and ALU requests. Optional timeout: RX_CTRL_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for a command byte
// WR_ADDR   | 0xAA seen, expecting register address
// WR_DATA   | address latched, expecting write data
// RD_ADDR   | 0xBB seen, expecting register address
// OP_A      | 0xCC seen, expecting operand A (reg 0)
// OP_B      | operand A written, expecting operand B (reg 1)
// ALU_FUN_S | clock gate on, expecting ALU function byte
// ALU_WAIT  | ALU running, bytes dropped until ALU_out_valid
module rx_control
   import rx_control_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic [WIDTH-1:0]      Rx_Data,
   input  logic                  Rx_Data_valid,
   input  logic                  ALU_out_valid,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic                  WrEn,
   output logic [WIDTH-1:0]      WrData,
   output logic                  RdEn,
   output logic                  ALU_EN,
   output logic [ALU_FUN_W-1:0]  ALU_FUN,
   output logic                  CLK_GATE_EN,
   output logic                  Cmd_error
);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [ADDR_WIDTH-1:0] address_q;
   logic [WIDTH-1:0]      wr_data_q;
   logic [ALU_FUN_W-1:0]  alu_fun_q;
   logic                  wr_en_q;
   logic                  rd_en_q;
   logic                  alu_en_q;
   logic                  gate_q;
   logic                  cmd_err_q;

   logic byte_accept;
   logic timeout_hit;

   // Bytes arriving while the ALU runs are dropped, so they are not "accepted".
   assign byte_accept = Rx_Data_valid && (state_q != ALU_WAIT);

`ifdef RX_CTRL_TIMEOUT_EN
   logic expire;

   rx_timeout_counter #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (CLK),
      .rst_n_i  (Reset),
      .clr_i    (byte_accept),
      .en_i     (state_q != IDLE),
      .expire_o (expire)
   );

   assign timeout_hit = expire && !(state_q == ALU_WAIT && ALU_out_valid);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         wr_addr_q <= '0;
         address_q <= '0;
         wr_data_q <= '0;
         alu_fun_q <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         alu_en_q  <= 1'b0;
         gate_q    <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         alu_en_q  <= 1'b0;
         cmd_err_q <= 1'b0;
         if (timeout_hit) begin
            state_q   <= IDLE;
            cmd_err_q <= 1'b1;
            gate_q    <= 1'b0;
         end else if (state_q == ALU_WAIT) begin
            if (ALU_out_valid) begin
               state_q <= IDLE;
               gate_q  <= 1'b0;
            end
         end else if (byte_accept) begin
            case (state_q)
               IDLE: begin
                  case (Rx_Data)
                     WIDTH'(CMD_WR):  state_q <= WR_ADDR;
                     WIDTH'(CMD_RD):  state_q <= RD_ADDR;
                     WIDTH'(CMD_OPS): state_q <= OP_A;
                     WIDTH'(CMD_ALU): begin
                        state_q <= ALU_FUN_S;
                        gate_q  <= 1'b1;
                     end
                     default:         cmd_err_q <= 1'b1;
                  endcase
               end
               WR_ADDR: begin
                  wr_addr_q <= Rx_Data[ADDR_WIDTH-1:0];
                  state_q   <= WR_DATA;
               end
               WR_DATA: begin
                  address_q <= wr_addr_q;
                  wr_data_q <= Rx_Data;
                  wr_en_q   <= 1'b1;
                  state_q   <= IDLE;
               end
               RD_ADDR: begin
                  address_q <= Rx_Data[ADDR_WIDTH-1:0];
                  rd_en_q   <= 1'b1;
                  state_q   <= IDLE;
               end
               OP_A: begin
                  address_q <= ADDR_WIDTH'(OP_A_ADDR);
                  wr_data_q <= Rx_Data;
                  wr_en_q   <= 1'b1;
                  state_q   <= OP_B;
               end
               OP_B: begin
                  address_q <= ADDR_WIDTH'(OP_B_ADDR);
                  wr_data_q <= Rx_Data;
                  wr_en_q   <= 1'b1;
                  gate_q    <= 1'b1;
                  state_q   <= ALU_FUN_S;
               end
               ALU_FUN_S: begin
                  alu_fun_q <= Rx_Data[ALU_FUN_W-1:0];
                  alu_en_q  <= 1'b1;
                  state_q   <= ALU_WAIT;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign Address     = address_q;
   assign WrEn        = wr_en_q;
   assign WrData      = wr_data_q;
   assign RdEn        = rd_en_q;
   assign ALU_EN      = alu_en_q;
   assign ALU_FUN     = alu_fun_q;
   assign CLK_GATE_EN = gate_q;
   assign Cmd_error   = cmd_err_q;

endmodule

// File: tb/tb_rx_control.sv
// Directed bench for rx_control: byte frames in, strobes and held outputs
// checked one cycle after each accepted byte.
module tb_rx_control;

   localparam int TIMEOUT = 1024;

   logic       CLK = 1'b0;
   logic       Reset = 1'b0;
   logic [7:0] Rx_Data = '0;
   logic       Rx_Data_valid = 1'b0;
   logic       ALU_out_valid = 1'b0;
   logic [3:0] Address;
   logic       WrEn;
   logic [7:0] WrData;
   logic       RdEn;
   logic       ALU_EN;
   logic [3:0] ALU_FUN;
   logic       CLK_GATE_EN;
   logic       Cmd_error;

   int vectors = 0;
   int miscompares = 0;

   rx_control #(
      .WIDTH          (8),
      .ADDR_WIDTH     (4),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .CLK           (CLK),
      .Reset         (Reset),
      .Rx_Data       (Rx_Data),
      .Rx_Data_valid (Rx_Data_valid),
      .ALU_out_valid (ALU_out_valid),
      .Address       (Address),
      .WrEn          (WrEn),
      .WrData        (WrData),
      .RdEn          (RdEn),
      .ALU_EN        (ALU_EN),
      .ALU_FUN       (ALU_FUN),
      .CLK_GATE_EN   (CLK_GATE_EN),
      .Cmd_error     (Cmd_error)
   );

   always #5 CLK = ~CLK;

   // strobes = {WrEn, RdEn, ALU_EN, Cmd_error, CLK_GATE_EN}
   logic [4:0] strobes;
   assign strobes = {WrEn, RdEn, ALU_EN, Cmd_error, CLK_GATE_EN};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      Rx_Data = b;
      Rx_Data_valid = 1'b1;
      tick();
      Rx_Data_valid = 1'b0;
   endtask

   initial begin
      // reset
      tick(); tick();
      chk("reset_strobes", 32'(strobes), 32'h0);
      chk("reset_addr",    32'(Address), 32'h0);
      chk("reset_wrdata",  32'(WrData),  32'h0);
      chk("reset_alufun",  32'(ALU_FUN), 32'h0);
      Reset = 1'b1;
      tick();

      // write frame
      send(8'hAA);  chk("wr_cmd_quiet",  32'(strobes), 32'h00);
      send(8'h05);  chk("wr_addr_quiet", 32'(strobes), 32'h00);
      send(8'h3C);  chk("wr_strobe",     32'(strobes), 32'h10);
      chk("wr_addr", 32'(Address), 32'h5);
      chk("wr_data", 32'(WrData),  32'h3C);
      tick();
      chk("wr_pulse_end", 32'(strobes), 32'h00);
      chk("wr_addr_hold", 32'(Address), 32'h5);

      // read frame with address truncation
      send(8'hBB);
      send(8'h17);  chk("rd_strobe", 32'(strobes), 32'h08);
      chk("rd_addr_trunc", 32'(Address), 32'h7);
      chk("rd_wrdata_hold", 32'(WrData), 32'h3C);
      tick();
      chk("rd_pulse_end", 32'(strobes), 32'h00);

      // ALU_out_valid outside ALU_WAIT is ignored
      ALU_out_valid = 1'b1; tick(); ALU_out_valid = 1'b0;
      chk("aluv_idle_ignored", 32'(strobes), 32'h00);

      // operand frame
      send(8'hCC);
      send(8'h12);  chk("opa_strobe", 32'(strobes), 32'h10);
      chk("opa_addr", 32'(Address), 32'h0);
      chk("opa_data", 32'(WrData),  32'h12);
      send(8'h34);  chk("opb_strobe_gate", 32'(strobes), 32'h11);
      chk("opb_addr", 32'(Address), 32'h1);
      chk("opb_data", 32'(WrData),  32'h34);
      tick();       chk("gate_before_alu_en", 32'(strobes), 32'h01);
      send(8'h01);  chk("alu_en_gate", 32'(strobes), 32'h05);
      chk("alu_fun_1", 32'(ALU_FUN), 32'h1);
      tick();       chk("alu_wait_gate", 32'(strobes), 32'h01);
      ALU_out_valid = 1'b1; tick(); ALU_out_valid = 1'b0;
      chk("gate_cleared", 32'(strobes), 32'h00);

      // DD frame, stray byte, then byte coinciding with ALU_out_valid
      send(8'hDD);  chk("dd_gate_on", 32'(strobes), 32'h01);
      send(8'h03);  chk("dd_alu_en", 32'(strobes), 32'h05);
      chk("alu_fun_3", 32'(ALU_FUN), 32'h3);
      send(8'hAA);  chk("stray_dropped", 32'(strobes), 32'h01);
      ALU_out_valid = 1'b1;
      send(8'hBB);
      ALU_out_valid = 1'b0;
      chk("both_valid_idle", 32'(strobes), 32'h00);
      send(8'h02);  chk("byte_was_dropped", 32'(strobes), 32'h02);
      chk("dd_no_write_addr", 32'(Address), 32'h1);
      chk("dd_no_write_data", 32'(WrData),  32'h34);

      // unknown byte followed back-to-back by a read frame
      send(8'h55);  chk("unknown_err", 32'(strobes), 32'h02);
      send(8'hBB);  chk("err_pulse_end", 32'(strobes), 32'h00);
      send(8'h02);  chk("rd_after_err", 32'(strobes), 32'h08);
      chk("rd_after_err_addr", 32'(Address), 32'h2);

      // reset mid-frame
      send(8'hAA);
      send(8'h05);
      Reset = 1'b0;
      #2;
      chk("midrst_strobes", 32'(strobes), 32'h00);
      chk("midrst_addr",    32'(Address), 32'h0);
      chk("midrst_wrdata",  32'(WrData),  32'h0);
      chk("midrst_alufun",  32'(ALU_FUN), 32'h0);
      tick();
      Reset = 1'b1;
      tick();
      send(8'h3C);  chk("partial_discarded", 32'(strobes), 32'h02);
      chk("partial_no_addr", 32'(Address), 32'h0);

      // write with truncated address
      send(8'hAA);
      send(8'hF9);
      send(8'h81);  chk("wr2_strobe", 32'(strobes), 32'h10);
      chk("wr2_addr_trunc", 32'(Address), 32'h9);
      chk("wr2_data", 32'(WrData), 32'h81);

`ifdef RX_CTRL_TIMEOUT_EN
      tick();
      send(8'hAA);
      for (int i = 0; i < TIMEOUT - 1; i++) tick();
      chk("timeout_not_yet", 32'(strobes), 32'h00);
      tick();
      chk("timeout_err", 32'(strobes), 32'h02);
      send(8'h3C);  chk("timeout_back_idle", 32'(strobes), 32'h02);
`endif

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
